// File: rtl/pcg_noise_source.sv
// pcg_noise_source
// PCG32 (XSH-RR) noise generator for the VGA pattern generator. A 64-bit LCG
// state is permuted into 32-bit words that are presented through a one-entry
// valid/ready output register. The state advances only when a word is
// actually produced, so the sequence is repeatable after reset or reseed.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset (state=SEED, outputs cleared)
//   seed_load   synchronous reseed: state<=seed_value, pending word dropped
//   seed_value  new 64-bit state value
//   step_en     request production of a new word
//   rnd_ready   consumer accepts rnd_out this cycle
//   rnd_valid   rnd_out holds an unconsumed word
//   rnd_out     PCG32 output word
//   word_count  words produced since reset/seed (16-bit, wraps)
module pcg_noise_source #(
  parameter logic [63:0] MULT = 64'h5851F42D4C957F2D,
  parameter logic [63:0] INC  = 64'h14057B7EF767814F,
  parameter logic [63:0] SEED = 64'h0000000000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [63:0] seed_value,
  input  logic        step_en,
  input  logic        rnd_ready,
  output logic        rnd_valid,
  output logic [31:0] rnd_out,
  output logic [15:0] word_count
);

  logic [63:0] state;
  logic [63:0] state_nxt;
  logic [31:0] perm_word;
  logic [31:0] xs;
  logic [4:0]  rot;
  logic        slot_free;
  logic        advance;

  // XSH-RR output permutation of the current (pre-update) state.
  // Left-shift amount is (-rot) mod 32 so rot=0 never shifts by 32.
  assign xs        = 32'((state ^ (state >> 18)) >> 27);
  assign rot       = state[63:59];
  assign perm_word = (xs >> rot) | (xs << (5'd0 - rot));

  // Product is truncated to 64 bits by the assignment width.
  assign state_nxt = state * MULT + INC;

  // Output slot can take a new word if empty or being consumed this edge.
  assign slot_free = !rnd_valid || rnd_ready;
  assign advance   = step_en && slot_free && !seed_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEED;
      rnd_valid  <= 1'b0;
      rnd_out    <= 32'd0;
      word_count <= 16'd0;
    end else if (seed_load) begin
      // Pending word is discarded even if the consumer is ready.
      state      <= seed_value;
      rnd_valid  <= 1'b0;
      word_count <= 16'd0;
    end else if (advance) begin
      rnd_out    <= perm_word;
      state      <= state_nxt;
      rnd_valid  <= 1'b1;
      word_count <= word_count + 16'd1;
    end else if (rnd_valid && rnd_ready) begin
      rnd_valid  <= 1'b0;
    end
  end

endmodule
